prog_loader: RTL and testbench

Program-memory controller that sequences the processor core. It holds the core in reset while a host streams 16-bit instruction words into an internal instruction RAM over a valid/ready handshake. It then releases the core and serves `instruction` combinationally from the core's `pc`. The run stops when the core runs off the end of the loaded program or a cycle budget expires. It sits between the host/boot interface and the processor's `clk`/`rst`/`pc`/`instruction` pins.

---
 rtl/prog_loader_pkg.sv | 17 +
 rtl/imem_ram.sv | 23 ++
 rtl/prog_loader.sv | 133 +++++++++++++
 tb/tb_prog_loader.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader and its instruction RAM.
package prog_loader_pkg;

  localparam int BITNESS = 16;
  localparam int WORD    = 16;
  localparam int INSTR_W = 16;

  localparam logic [INSTR_W-1:0] FILL_DEFAULT = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_STOP = 2'd3
  } state_t;

endpackage

// File: rtl/imem_ram.sv
// Instruction RAM: one synchronous write port, one asynchronous read port, contents not reset.
module imem_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH),
  parameter int W     = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/prog_loader.sv
// Program loader: holds the core in reset while the host streams a program, then runs it.
// Optional build macro PROG_LOADER_CHECKSUM_EN enables the additive checksum of loaded words.
//
//   state   | meaning
//   IDLE    | core held in reset, waiting for load_start
//   LOAD    | accepting host words into the instruction RAM
//   RUN     | core released, instructions served from cpu_pc
//   STOP    | run ended (run-off or budget), core held in reset
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int                 DEPTH = 256,
  parameter logic [INSTR_W-1:0] FILL  = FILL_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_start,
  input  logic [BITNESS-1:0]       cycle_limit,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [INSTR_W-1:0]       ld_data,
  input  logic                     ld_last,
  output logic                     cpu_rst,
  input  logic [BITNESS-1:0]       cpu_pc,
  output logic [INSTR_W-1:0]       cpu_instr,
  output logic [1:0]               state,
  output logic                     done,
  output logic                     err,
  output logic [$clog2(DEPTH):0]   prog_len,
  output logic [INSTR_W-1:0]       checksum
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LEN_W = AW + 1;

  state_t              state_q, state_d;
  logic                cpu_rst_q, cpu_rst_d;
  logic                done_q, done_d;
  logic                err_q;
  logic [LEN_W-1:0]    len_q;
  logic [BITNESS-1:0]  cnt_q, limit_q;
  logic [INSTR_W-1:0]  ram_rdata;
  logic                xfer, last_slot, pc_in_range, budget_hit;

  assign ld_ready    = (state_q == ST_LOAD) && !load_start;
  assign xfer        = ld_valid && ld_ready;
  assign last_slot   = (len_q == LEN_W'(DEPTH - 1));
  // Widen both sides so any cpu_pc beyond DEPTH compares correctly.
  assign pc_in_range = ({1'b0, cpu_pc} < (BITNESS + 1)'(len_q));
  assign budget_hit  = (limit_q != '0) && (cnt_q == limit_q - BITNESS'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cpu_rst_q <= cpu_rst_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (load_start) begin
      state_d = ST_LOAD;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_LOAD: begin
          if (xfer && ld_last)        state_d = ST_RUN;
          else if (xfer && last_slot) state_d = ST_IDLE;
        end
        ST_RUN:  if (!pc_in_range || budget_hit) state_d = ST_STOP;
        ST_STOP: state_d = ST_STOP;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cpu_rst_d = (state_d != ST_RUN);
    done_d    = (state_d == ST_STOP) && (state_q != ST_STOP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q   <= 1'b0;
      len_q   <= '0;
      cnt_q   <= '0;
      limit_q <= '0;
    end else if (load_start) begin
      err_q   <= 1'b0;
      len_q   <= '0;
      cnt_q   <= '0;
      limit_q <= cycle_limit;
    end else begin
      if (xfer) len_q <= len_q + LEN_W'(1);
      if (xfer && last_slot && !ld_last) err_q <= 1'b1;
      if (state_q == ST_RUN) cnt_q <= cnt_q + BITNESS'(1);
    end
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [INSTR_W-1:0] sum_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             sum_q <= '0;
    else if (load_start) sum_q <= '0;
    else if (xfer)       sum_q <= sum_q + ld_data;
  end
  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

  imem_ram #(.DEPTH(DEPTH), .AW(AW), .W(INSTR_W)) u_imem (
    .clk   (clk),
    .we    (xfer),
    .waddr (len_q[AW-1:0]),
    .wdata (ld_data),
    .raddr (cpu_pc[AW-1:0]),
    .rdata (ram_rdata)
  );

  assign cpu_instr = pc_in_range ? ram_rdata : FILL;
  assign cpu_rst   = cpu_rst_q;
  assign done      = done_q;
  assign err       = err_q;
  assign prog_len  = len_q;
  assign state     = state_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: vector table for loading, scoreboard for served instructions.
module tb_prog_loader;
  import prog_loader_pkg::*;

  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam logic [15:0] TB_FILL = 16'hDEAD;

  logic               clk = 1'b0;
  logic               rst, load_start, ld_valid, ld_last;
  logic [15:0]        ld_data;
  logic [BITNESS-1:0] cycle_limit, cpu_pc;
  logic               ld_ready, cpu_rst, done, err;
  logic [15:0]        cpu_instr, checksum;
  logic [1:0]         state;
  logic [LW-1:0]      prog_len;

  prog_loader #(.DEPTH(DEPTH), .FILL(TB_FILL)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .cycle_limit(cycle_limit),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
    .cpu_rst(cpu_rst), .cpu_pc(cpu_pc), .cpu_instr(cpu_instr), .state(state),
    .done(done), .err(err), .prog_len(prog_len), .checksum(checksum)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  logic [15:0] sb_q[$];

  typedef struct {
    logic [15:0] data;
    logic        valid;
    logic        last;
    logic        exp_ready;
    int          exp_len;
  } ld_vec_t;

  ld_vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [BITNESS-1:0] lim);
    load_start  = 1'b1;
    cycle_limit = lim;
    tick();
    load_start  = 1'b0;
  endtask

  task automatic send(input logic [15:0] d, input logic last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  initial begin
    int n_run;
    logic [15:0] exp_w;

    vecs[0] = '{16'h1111, 1'b1, 1'b0, 1'b1, 1};
    vecs[1] = '{16'h2222, 1'b0, 1'b0, 1'b1, 1};
    vecs[2] = '{16'h2222, 1'b1, 1'b0, 1'b1, 2};
    vecs[3] = '{16'h3333, 1'b1, 1'b1, 1'b1, 3};
    vecs[4] = '{16'h4444, 1'b1, 1'b0, 1'b0, 3};

    rst = 1'b1; load_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
    ld_data = '0; cycle_limit = '0; cpu_pc = '0;
    #12;
    check("rst_state", 32'(state), 32'(ST_IDLE));
    check("rst_cpu_rst", 32'(cpu_rst), 1);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_len", 32'(prog_len), 0);
    check("rst_ready", 32'(ld_ready), 0);
    check("rst_checksum", 32'(checksum), 0);
    rst = 1'b0;
    tick();

    // Test 1: three-word program, run-off at pc=3
    load_start = 1'b1;
    #1;
    check("ready_gated_by_start", 32'(ld_ready), 0);
    tick();
    load_start = 1'b0;
    check("t1_state_load", 32'(state), 32'(ST_LOAD));
    for (int i = 0; i < 4; i++) begin
      ld_valid = vecs[i].valid;
      ld_data  = vecs[i].data;
      ld_last  = vecs[i].last;
      #1;
      check($sformatf("t1_ready_%0d", i), 32'(ld_ready), 32'(vecs[i].exp_ready));
      if (vecs[i].valid && ld_ready) sb_q.push_back(vecs[i].data);
      tick();
      check($sformatf("t1_len_%0d", i), 32'(prog_len), 32'(vecs[i].exp_len));
    end
    check("t1_state_run", 32'(state), 32'(ST_RUN));
    check("t1_cpu_rst_low", 32'(cpu_rst), 0);
    // A stray word after the run started must be ignored
    ld_valid = vecs[4].valid; ld_data = vecs[4].data; ld_last = vecs[4].last;
    #1;
    check("t1_ready_in_run", 32'(ld_ready), 32'(vecs[4].exp_ready));
    ld_valid = 1'b0; ld_last = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cpu_pc = BITNESS'(k);
      #1;
      if (sb_q.size() == 0) check("t1_sb_empty", 0, 1);
      else begin
        exp_w = sb_q.pop_front();
        check($sformatf("t1_instr_pc%0d", k), 32'(cpu_instr), 32'(exp_w));
      end
      check($sformatf("t1_run_pc%0d", k), 32'(state), 32'(ST_RUN));
      tick();
    end
    check("t1_len_after_stray", 32'(prog_len), vecs[4].exp_len);
    cpu_pc = 3;
    #1;
    check("t1_instr_fill", 32'(cpu_instr), 32'(TB_FILL));
    check("t1_still_run", 32'(state), 32'(ST_RUN));
    tick();
    check("t1_stop", 32'(state), 32'(ST_STOP));
    check("t1_done_pulse", 32'(done), 1);
    check("t1_cpu_rst_high", 32'(cpu_rst), 1);
    tick();
    check("t1_done_single", 32'(done), 0);
    check("t1_len_final", 32'(prog_len), 3);

    // Test 2: budget of 5 cycles on a two-word loop
    cpu_pc = 0;
    start_load(BITNESS'(5));
    sb_q.push_back(16'hA0A0);
    send(16'hA0A0, 1'b0);
    sb_q.push_back(16'hB1B1);
    send(16'hB1B1, 1'b1);
    check("t2_state_run", 32'(state), 32'(ST_RUN));
    n_run = 0;
    for (int c = 0; c < 20 && state != ST_STOP; c++) begin
      cpu_pc = BITNESS'(c % 2);
      #1;
      if (c < 2 && sb_q.size() != 0) begin
        exp_w = sb_q.pop_front();
        check($sformatf("t2_instr_%0d", c), 32'(cpu_instr), 32'(exp_w));
      end
      if (!cpu_rst) n_run++;
      tick();
    end
    check("t2_state_stop", 32'(state), 32'(ST_STOP));
    check("t2_run_cycles", 32'(n_run), 5);
    check("t2_done", 32'(done), 1);

    // Test 3: overflow without ld_last
    cpu_pc = 0;
    start_load('0);
    ld_valid = 1'b1; ld_last = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      ld_data = 16'(16'h0100 + i);
      #1;
      if (!ld_ready) check($sformatf("t3_ready_%0d", i), 32'(ld_ready), 1);
      tick();
    end
    ld_valid = 1'b0;
    check("t3_err", 32'(err), 1);
    check("t3_idle", 32'(state), 32'(ST_IDLE));
    check("t3_len", 32'(prog_len), DEPTH);
    tick(); tick();
    check("t3_cpu_rst_held", 32'(cpu_rst), 1);
    check("t3_still_idle", 32'(state), 32'(ST_IDLE));
    start_load('0);
    check("t3_err_cleared", 32'(err), 0);
    check("t3_relaunch_load", 32'(state), 32'(ST_LOAD));

    // Test 4: restart in LOAD, checksum, abort in RUN
    send(16'h0AAA, 1'b0);
    send(16'h0BBB, 1'b0);
    check("t4_len2", 32'(prog_len), 2);
    load_start = 1'b1; ld_valid = 1'b1; ld_data = 16'h0CCC;
    #1;
    check("t4_ready_during_start", 32'(ld_ready), 0);
    tick();
    load_start = 1'b0; ld_valid = 1'b0;
    check("t4_len_cleared", 32'(prog_len), 0);
    check("t4_state_load", 32'(state), 32'(ST_LOAD));
    check("t4_sum_cleared", 32'(checksum), 0);
    send(16'hFFFF, 1'b0);
    send(16'h0002, 1'b1);
`ifdef PROG_LOADER_CHECKSUM_EN
    check("t4_checksum", 32'(checksum), 32'h0001);
`else
    check("t4_checksum_off", 32'(checksum), 0);
`endif
    check("t4_run", 32'(state), 32'(ST_RUN));
    #1;
    check("t4_instr0", 32'(cpu_instr), 32'h0000_FFFF);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("t4_abort_cpu_rst", 32'(cpu_rst), 1);
    check("t4_abort_load", 32'(state), 32'(ST_LOAD));

    // Test 5: async reset mid-LOAD
    send(16'h5555, 1'b0);
    check("t5_len1", 32'(prog_len), 1);
    #2;
    rst = 1'b1;
    #1;
    check("t5_async_state", 32'(state), 32'(ST_IDLE));
    check("t5_async_len", 32'(prog_len), 0);
    check("t5_async_ready", 32'(ld_ready), 0);
    check("t5_async_cpu_rst", 32'(cpu_rst), 1);
    rst = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
